// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte path between NUM_REQ requesters.
// Grant registered 1 cycle after valid; data/valid/ready mux is combinational.
// Grant held while tx_ready is low or owner stalls; released on last or after MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [PTR_W-1:0]   gidx, gidx_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_g;
  logic               xfer;
  logic               burst_hit;
  logic [PTR_W:0]     scan_idx;
  logic               found;

  // Owner mux: route the granted requester onto the TX path; grant is one-hot or zero.
  always_comb begin
    tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        tx_data = tx_data | req_data[i*DATA_W +: DATA_W];
      end
    end
    tx_valid  = |(req_valid & grant);
    req_ready = {NUM_REQ{tx_ready}} & grant;
    last_g    = |(req_last & grant);
    xfer      = tx_valid & tx_ready;
    cnt_inc   = cnt + 1'b1;
    burst_hit = (MAX_BURST != 0) && (cnt_inc == CNT_W'(MAX_BURST));
  end

  assign busy = |grant;

  // Arbitration state register; async reset drops the grant at once and rewinds priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      gidx  <= gidx_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: rotating priority scan when idle, beat counting and release when locked.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    scan_idx  = '0;
    found     = 1'b0;
    case (state)
      IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          // Wrap explicitly so non-power-of-2 requester counts stay in range.
          scan_idx = {1'b0, ptr} + (PTR_W+1)'(i);
          if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
          end
          if (!found && req_valid[scan_idx[PTR_W-1:0]]) begin
            found     = 1'b1;
            gidx_nxt  = scan_idx[PTR_W-1:0];
            grant_nxt = NUM_REQ'(1) << scan_idx[PTR_W-1:0];
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (xfer) begin
          cnt_nxt = cnt_inc;
          // A burst-limit release is not a message end; the owner re-arbitrates later.
          if (last_g || burst_hit) begin
            grant_nxt = '0;
            cnt_nxt   = '0;
            ptr_nxt   = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with per-requester byte queues and a TX scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// tx_ready is driven directly to exercise stalls.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_last  = '0;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        busy;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } ent_t;

  typedef struct {
    logic [3:0] g;
    logic [7:0] d;
  } exp_t;

  ent_t rq [4][$];
  exp_t sb [$];
  int   tq [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [3:0] fire_s = '0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Requester models: pop the head on an accepted handshake, then present the next byte.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire_s[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = rq[i][0].d;
        req_last[i]         = rq[i][0].l;
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  end

  // Scoreboard: every byte the TX side accepts must match the next expected byte and owner.
  always @(negedge clk) begin
    cyc    = cyc + 1;
    fire_s = req_valid & req_ready;
    if (!reset && tx_valid && tx_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected obs=%h exp=none", tx_data);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (tx_data === e.d) else begin
          errors++;
          $error("FAIL sb_data obs=%h exp=%h", tx_data, e.d);
        end
        checks++;
        assert (grant === e.g) else begin
          errors++;
          $error("FAIL sb_grant obs=%b exp=%b", grant, e.g);
        end
      end
      tq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int r, input logic [7:0] d, input logic l);
    ent_t e;
    e.d = d;
    e.l = l;
    rq[r].push_back(e);
  endtask

  task automatic expect_byte(input logic [3:0] g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] g, input int budget);
    int n = 0;
    while (grant !== g && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {28'h0, grant}, {28'h0, g});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, {28'h0, grant}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_txv"}, {31'h0, tx_valid}, 32'h0);
    chk({tag, "_rdy"}, {28'h0, req_ready}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle_outputs("rst_hold");
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b1;

    // Reset held 3 cycles, then released with no traffic.
    repeat (3) begin
      @(negedge clk);
      chk_idle_outputs("rst_hold");
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_idle_outputs("rst_rel");
    end

    // Single 3-byte message from requester 1, with exact grant latency.
    send(1, 8'h41, 1'b0);
    send(1, 8'h42, 1'b0);
    send(1, 8'h43, 1'b1);
    expect_byte(4'b0010, 8'h41);
    expect_byte(4'b0010, 8'h42);
    expect_byte(4'b0010, 8'h43);
    @(negedge clk);
    chk("msg1_pregrant", {28'h0, grant}, 32'h0);
    @(negedge clk);
    chk("msg1_grant", {28'h0, grant}, 32'h2);
    chk("msg1_busy", {31'h0, busy}, 32'h1);
    chk("msg1_rdy", {28'h0, req_ready}, 32'h2);
    wait_empty("msg1_done", 50);
    @(negedge clk);
    chk("msg1_release", {28'h0, grant}, 32'h0);
    chk("msg1_idle_busy", {31'h0, busy}, 32'h0);

    // All four requesters with back-to-back 1-byte messages: strict rotation, 2 cycles apart.
    do_reset();
    tq.delete();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 4; r++) begin
        send(r, 8'h10 + 8'(k*4 + r), 1'b1);
        expect_byte(4'(1 << r), 8'h10 + 8'(k*4 + r));
      end
    end
    wait_empty("rr_done", 100);
    chk("rr_count", tq.size(), 8);
    for (int k = 1; k < tq.size(); k++) begin
      chk("rr_spacing", tq[k] - tq[k-1], 2);
    end

    // Burst limit of 4: requester 2 is cut after 4 bytes, requester 3 goes, then 2 finishes.
    for (int b = 0; b < 6; b++) begin
      send(2, 8'h20 + 8'(b), (b == 5) ? 1'b1 : 1'b0);
    end
    send(3, 8'h3A, 1'b1);
    for (int b = 0; b < 4; b++) expect_byte(4'b0100, 8'h20 + 8'(b));
    expect_byte(4'b1000, 8'h3A);
    expect_byte(4'b0100, 8'h24);
    expect_byte(4'b0100, 8'h25);
    wait_empty("burst_done", 100);

    // Stall: tx_ready low for 100 cycles while requester 0 holds 0x55.
    @(posedge clk);
    #1 tx_ready = 1'b0;
    send(0, 8'h55, 1'b1);
    expect_byte(4'b0001, 8'h55);
    wait_grant("stall_grant", 4'b0001, 20);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      chk("stall_rdy", {28'h0, req_ready}, 32'h0);
      chk("stall_data", {24'h0, tx_data}, 32'h55);
      chk("stall_hold", {28'h0, grant}, 32'h1);
    end
    chk("stall_pending", sb.size(), 1);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    chk("stall_rise_rdy", {28'h0, req_ready}, 32'h1);
    wait_empty("stall_done", 5);
    @(negedge clk);
    chk("stall_release", {28'h0, grant}, 32'h0);

    // Mid-message reset while requester 3 owns the line.
    @(posedge clk);
    #1 tx_ready = 1'b0;
    send(3, 8'h31, 1'b0);
    send(3, 8'h32, 1'b0);
    send(3, 8'h33, 1'b1);
    wait_grant("mrst_grant", 4'b1000, 20);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_idle_outputs("mrst_async");
    rq[3].delete();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    send(0, 8'hA0, 1'b1);
    send(3, 8'hA3, 1'b1);
    expect_byte(4'b0001, 8'hA0);
    expect_byte(4'b1000, 8'hA3);
    tx_ready = 1'b1;
    wait_empty("mrst_after", 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
